wallace_product_accumulator: RTL and testbench

WALLACE_PRODUCT_ACCUMULATOR -- requirements
Module: wallace_product_accumulator

---
 rtl/wallace_product_accumulator.sv | 92 +++++++++
 tb/tb_wallace_product_accumulator.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/wallace_product_accumulator.sv
// Accumulates a group of 16-bit products into one sum/count/overflow result; result valid 1 cycle after the last beat.
// A held result blocks input until out_ready; in_ready depends only on state and clr, and all outputs come from flops.
module wallace_product_accumulator #(
   parameter int ACC_W = 24,
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_product,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [ACC_W:0]     add_w;

   // One extra bit catches the carry out of the accumulator.
   assign add_w = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, in_product};

   assign in_ready  = (state_q == ACCUM) && !clr;
   assign out_valid = (state_q == HOLD);
   assign out_sum   = acc_q;
   assign out_count = cnt_q;
   assign out_ovf   = ovf_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (clr) begin
         state_d = ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            ACCUM: begin
               if (in_valid) begin
                  acc_d = add_w[ACC_W-1:0];
                  ovf_d = ovf_q | add_w[ACC_W];
                  if (!(&cnt_q)) begin
                     cnt_d = cnt_q + 1'b1;
                  end
                  if (in_last) begin
                     state_d = HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_d = ACCUM;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_wallace_product_accumulator.sv
// Randomized and directed bench for wallace_product_accumulator against a group-list reference model.
module tb_wallace_product_accumulator;

   localparam int ACC_W = 24;
   localparam int CNT_W = 9;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             clr = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [15:0]      in_product = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: the products of the current group, and whether it is complete.
   int unsigned grp[$];
   bit          holding = 1'b0;

   wallace_product_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic longint m_total();
      longint t = 0;
      foreach (grp[i]) t += grp[i];
      return t;
   endfunction

   function automatic logic [31:0] m_sum();
      return 32'(m_total() % (longint'(1) << ACC_W));
   endfunction

   function automatic logic [31:0] m_ovf();
      return {31'd0, m_total() >= (longint'(1) << ACC_W)};
   endfunction

   function automatic logic [31:0] m_cnt();
      int mx = (1 << CNT_W) - 1;
      return (grp.size() > mx) ? mx : grp.size();
   endfunction

   // One clock: drive inputs, check everything mid-cycle, then advance the model at the edge.
   task automatic cyc(input bit r, input bit c, input bit v, input logic [15:0] p,
                      input bit l, input bit ordy);
      rst = r; clr = c; in_valid = v; in_product = p; in_last = l; out_ready = ordy;
      @(negedge clk);
      chk("in_ready",  {31'd0, in_ready},  {31'd0, !holding && !c});
      chk("out_valid", {31'd0, out_valid}, {31'd0, holding});
      chk("out_sum",   32'(out_sum),       m_sum());
      chk("out_count", 32'(out_count),     m_cnt());
      chk("out_ovf",   {31'd0, out_ovf},   m_ovf());
      @(posedge clk);
      if (r || c) begin
         grp.delete();
         holding = 1'b0;
      end else if (!holding && v) begin
         grp.push_back(p);
         if (l) holding = 1'b1;
      end else if (holding && ordy) begin
         grp.delete();
         holding = 1'b0;
      end
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sum",   32'(out_sum),       32'd0);
      chk("rst_count", 32'(out_count),     32'd0);
      chk("rst_ovf",   {31'd0, out_ovf},   32'd0);
      chk("rst_ready", {31'd0, in_ready},  32'd1);

      // 255*255, 1, 2(last)
      cyc(0, 0, 1, 16'd65025, 0, 1);
      cyc(0, 0, 1, 16'd1, 0, 1);
      cyc(0, 0, 1, 16'd2, 1, 1);
      chk("g1_valid", {31'd0, out_valid}, 32'd1);
      chk("g1_sum",   32'(out_sum),       32'd65028);
      chk("g1_count", 32'(out_count),     32'd3);
      chk("g1_ovf",   {31'd0, out_ovf},   32'd0);
      cyc(0, 0, 1, 16'd9, 0, 1);
      chk("g1_drain_sum", 32'(out_sum), 32'd0);

      // Held result with stalled downstream and input pressing.
      cyc(0, 0, 1, 16'd100, 1, 0);
      repeat (5) cyc(0, 0, 1, 16'd55, 0, 0);
      cyc(0, 0, 1, 16'd55, 0, 1);
      chk("hold_clr_sum",   32'(out_sum),      32'd0);
      chk("hold_clr_ready", {31'd0, in_ready}, 32'd1);

      // 256 beats of 65025
      for (int i = 0; i < 256; i++) cyc(0, 0, 1, 16'd65025, i == 255, 0);
      chk("big_sum",   32'(out_sum),     32'hFE0100);
      chk("big_count", 32'(out_count),   32'd256);
      chk("big_ovf",   {31'd0, out_ovf}, 32'd0);
      cyc(0, 0, 0, 16'd0, 0, 1);

      // Run far enough past 2^24 to wrap: 259 * 65025 = 16841475.
      for (int i = 0; i < 259; i++) cyc(0, 0, 1, 16'd65025, i == 258, 0);
      chk("wrap_sum", 32'(out_sum),     32'd64259);
      chk("wrap_ovf", {31'd0, out_ovf}, 32'd1);
      cyc(0, 0, 0, 16'd0, 0, 1);

      // Count saturation.
      for (int i = 0; i < 515; i++) cyc(0, 0, 1, 16'd1, i == 514, 0);
      chk("sat_count", 32'(out_count), 32'd511);
      chk("sat_sum",   32'(out_sum),   32'd515);
      cyc(0, 0, 0, 16'd0, 0, 1);

      // clr colliding with a beat.
      cyc(0, 0, 1, 16'd11, 0, 1);
      cyc(0, 0, 1, 16'd12, 0, 1);
      cyc(0, 1, 1, 16'd13, 0, 1);
      chk("clr_sum",   32'(out_sum),   32'd0);
      chk("clr_count", 32'(out_count), 32'd0);
      cyc(0, 0, 1, 16'd7, 1, 0);
      chk("clr_after_sum", 32'(out_sum), 32'd7);

      // clr discards a held result.
      cyc(0, 1, 0, 16'd0, 0, 0);
      chk("clr_hold_valid", {31'd0, out_valid}, 32'd0);

      // rst while holding.
      cyc(0, 0, 1, 16'd40, 1, 0);
      cyc(1, 0, 0, 16'd0, 0, 0);
      chk("rst_hold_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_hold_sum",   32'(out_sum),       32'd0);
      chk("rst_hold_ready", {31'd0, in_ready},  32'd1);

      // Back-to-back groups {3}, {4,5}.
      cyc(0, 0, 1, 16'd3, 1, 1);
      chk("b2b_sum1", 32'(out_sum),   32'd3);
      chk("b2b_cnt1", 32'(out_count), 32'd1);
      cyc(0, 0, 1, 16'd4, 0, 1);
      cyc(0, 0, 1, 16'd4, 0, 1);
      cyc(0, 0, 1, 16'd5, 1, 1);
      chk("b2b_sum2", 32'(out_sum),   32'd9);
      chk("b2b_cnt2", 32'(out_count), 32'd2);
      cyc(0, 0, 0, 16'd0, 0, 1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
             ($urandom % 4) != 0, 16'($urandom), $urandom_range(0, 7) == 0,
             ($urandom % 2) == 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
